// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the sequential ALU blocks. Any block that walks
// through an idle / running / finished sequence uses the same state
// encoding, so state values read the same way across designs.
//
// Contents:
//   aluState_e : IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aluState_e;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder. This is the only arithmetic element of the serial
// adder, which reuses it once per clock.
//
// Ports:
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Plain gate-level sum and carry, so no "+" ends up on the datapath.
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder. It adds one bit pair per clock, LSB first, through a
// single full_adder. A WIDTH-bit addition takes WIDTH clocks after the
// start edge. The result registers change only when a computation
// completes, and they hold their value while the next one runs.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin an addition (honoured in IDLE or DONE, ignored in RUN)
//   A, B     : WIDTH-bit operands, latched on the start edge
//   Cin      : carry into bit 0, latched on the start edge
//   Sum      : registered WIDTH-bit result
//   Cout     : carry out of bit WIDTH-1
//   Overflow : two's-complement overflow (carry into MSB ^ carry out of MSB)
//   busy     : high while the state is RUN
//   done     : one-cycle pulse while the state is DONE
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  aluState_e        r_state;
  aluState_e        w_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CNTW-1:0]  r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_resNext;

  // One shared bit-slice adder, fed from the low ends of the operand shift
  // registers and the carry flip-flop.
  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  // The result shifter stores only WIDTH-1 bits. On the final step the
  // current sum bit becomes the MSB of the completed word directly, so no
  // stored bit goes unused.
  assign w_resNext = {w_s, r_res};

  // The counter starts at 0 on the start edge, so the step that sees
  // WIDTH-1 is the last bit pair.
  assign w_last = (r_cnt == CNTW'(WIDTH - 1));

  // State register. Reset wins over everything else, including a start
  // request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode. IDLE and DONE both accept start, which
  // lets back-to-back additions run with no dead cycle between them.
  // RUN ignores start completely.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath. A start latches the operands and carry and clears the
  // counter. Each RUN step shifts the operands right by one bit, captures
  // the carry and shifts the sum bit in from the top. The visible result
  // registers load only on the last step.
  // Overflow compares the carry into the MSB (still held in r_carry at
  // that point) with the carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= Cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_res   <= w_resNext[WIDTH-1:1];
      r_cnt   <= r_cnt + CNTW'(1);
      if (w_last) begin
        r_sum  <= w_resNext;
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder at WIDTH=4. A cycle model tracks
// when the adder should be idle, running or done. It computes the expected
// result with ordinary integer arithmetic when a start is accepted and
// pushes it onto a scoreboard queue. A monitor pops that queue on every
// done pulse. Directed scenarios add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic             busy;
  logic             done;

  int checkCount = 0;
  int failCount  = 0;

  logic [WIDTH+1:0] sbQueue[$];

  int               mState = 0;
  int               mCnt   = 0;
  logic [WIDTH+1:0] mPending = '0;
  logic [WIDTH+1:0] mHeld    = '0;
  logic             monitorOn = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference result packed as {overflow, cout, sum}. The overflow term
  // comes from the carry into the MSB, taken from a sum of the low bits.
  function automatic logic [WIDTH+1:0] refAdd(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic c);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    low  = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c};
    return {low[WIDTH-1] ^ full[WIDTH], full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Cycle model of the control behaviour. It pushes the expected result on
  // every accepted start and takes over the held outputs when the addition
  // should finish.
  always @(posedge clk) begin
    if (rst) begin
      mState = 0;
      mCnt   = 0;
      mHeld  = '0;
      sbQueue.delete();
    end else begin
      case (mState)
        1: begin
          mCnt++;
          if (mCnt == WIDTH) begin
            mState = 2;
            mHeld  = mPending;
          end
        end
        default: begin
          if (start) begin
            mPending = refAdd(A, B, Cin);
            sbQueue.push_back(mPending);
            mState = 1;
            mCnt   = 0;
          end else begin
            mState = 0;
          end
        end
      endcase
    end
  end

  // Per-cycle monitor on the falling edge. It checks status and held
  // outputs against the model and pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    logic [WIDTH+1:0] exp;
    if (monitorOn) begin
      checkOutput("busy", busy, (mState == 1));
      checkOutput("done", done, (mState == 2));
      checkOutput("heldSum", Sum, mHeld[WIDTH-1:0]);
      checkOutput("heldCout", Cout, mHeld[WIDTH]);
      checkOutput("heldOvf", Overflow, mHeld[WIDTH+1]);
      if (done === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("sbSum", Sum, exp[WIDTH-1:0]);
          checkOutput("sbCout", Cout, exp[WIDTH]);
          checkOutput("sbOvf", Overflow, exp[WIDTH+1]);
        end
      end
    end
  end

  // Drives a one-cycle start pulse with the given operands. Call it on a
  // falling edge. It returns on the following falling edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c);
    A     = a;
    B     = b;
    Cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits, with a bound, for the next done pulse and reports how many
  // falling edges it took.
  task automatic waitDone(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < maxCycles);
    if (done !== 1'b1) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int doneCount;
    int lastDone;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sum", Sum, 0);
    checkOutput("rst_cout", Cout, 0);
    checkOutput("rst_ovf", Overflow, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    monitorOn = 1'b1;
    rst = 1'b0;

    // 5 + 3: latency, result and overflow.
    applyStimulus(4'd5, 4'd3, 1'b0);
    waitDone("r029", 10, lat);
    checkOutput("r029_latency", lat, WIDTH);
    checkOutput("r029_sum", Sum, 8);
    checkOutput("r029_cout", Cout, 0);
    checkOutput("r029_ovf", Overflow, 1);

    // Wrap-around cases with carry out.
    applyStimulus(4'd7, 4'd9, 1'b0);
    waitDone("r030a", 10, lat);
    checkOutput("r030a_sum", Sum, 0);
    checkOutput("r030a_cout", Cout, 1);
    checkOutput("r030a_ovf", Overflow, 0);
    applyStimulus(4'd15, 4'd0, 1'b1);
    waitDone("r030b", 10, lat);
    checkOutput("r030b_sum", Sum, 0);
    checkOutput("r030b_cout", Cout, 1);
    checkOutput("r030b_ovf", Overflow, 0);

    // Operands change right after the latching edge.
    applyStimulus(4'd6, 4'd6, 1'b1);
    A   = 4'd15;
    B   = 4'd15;
    Cin = 1'b0;
    waitDone("latch", 10, lat);
    checkOutput("latch_sum", Sum, 13);
    checkOutput("latch_ovf", Overflow, 1);

    // A start in the middle of RUN must be ignored.
    applyStimulus(4'd2, 4'd3, 1'b0);
    A     = 4'd9;
    B     = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("r032", 10, lat);
    checkOutput("r032_sum", Sum, 5);
    doneCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("r032_noExtraDone", doneCount, 0);

    // Start held high: a done pulse every fifth cycle, with Sum holding.
    A         = 4'd1;
    B         = 4'd1;
    Cin       = 1'b0;
    start     = 1'b1;
    doneCount = 0;
    lastDone  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (doneCount > 0) checkOutput("r031_interval", i - lastDone, 5);
        doneCount++;
        lastDone = i;
      end
      if (doneCount > 0) checkOutput("r031_sumHold", Sum, 2);
    end
    start = 1'b0;
    checkOutput("r031_pulses", doneCount, 4);

    // Reset two cycles into RUN aborts the addition.
    @(negedge clk);
    applyStimulus(4'd5, 4'd5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("r033_sum", Sum, 0);
    checkOutput("r033_cout", Cout, 0);
    checkOutput("r033_ovf", Overflow, 0);
    checkOutput("r033_busy", busy, 0);
    checkOutput("r033_done", done, 0);
    doneCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("r033_noDone", doneCount, 0);

    // Random operands, some issued back-to-back from the DONE cycle.
    for (int i = 0; i < 12; i++) begin
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
      waitDone("rand", 10, lat);
      checkOutput("rand_latency", lat, WIDTH);
      if (i % 3 != 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", sbQueue.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
